// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch (IF) stage of the 5-stage pipeline.
// It owns the PC and keeps a single imem request outstanding. It presents
// {valid, pc, pc+4, instruction} to decode. A one-entry skid buffer catches a
// response that returns while decode is stalled. A redirect from execute
// reloads the PC, flushes the IF/ID entry and discards any in-flight response.
//
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   pc_new_i, pc_select_i       redirect target / strobe from execute
//   stall_i                     decode stall, holds the IF/ID entry
//   imem_req_o, imem_addr_o     fetch request and word-aligned address
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i, imem_rdata_i response strobe / instruction word
//   valid_o, pc_o, pcsrc_o,     IF/ID entry: valid, PC, PC+4, instruction
//   instruction_o               (NOP_INSTR whenever valid_o = 0)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | request asserted for pc_q, waiting for grant
// S_WAIT  | one granted request outstanding, waiting for rvalid
// S_HOLD  | skid buffer full, waiting for decode to un-stall

module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] pc_new_i,
   input  logic        pc_select_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcsrc_o,
   output logic [31:0] instruction_o
);

   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic        discard_q, discard_d;

   logic        valid_q, valid_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] pcsrc_q, pcsrc_d;
   logic [31:0] instr_q, instr_d;

   logic        redirect;
   logic [31:0] target;
   logic        out_free;
   logic        load_resp;
   logic        load_skid;

   assign redirect = pc_select_i;
   assign target   = pc_new_i & WORD_MASK;
   assign out_free = !stall_i || !valid_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      discard_d    = discard_q;
      load_resp    = 1'b0;
      load_skid    = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (imem_gnt_i) begin
               req_pc_d = pc_q;
               state_d  = S_WAIT;
               if (redirect) begin
                  // Request already went out for the old path; drop its reply.
                  pc_d      = target;
                  discard_d = 1'b1;
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end else if (redirect) begin
               pc_d = target;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d = target;
            end
            if (imem_rvalid_i) begin
               if (discard_q || redirect) begin
                  discard_d = 1'b0;
                  state_d   = S_FETCH;
               end else if (out_free) begin
                  load_resp = 1'b1;
                  state_d   = S_FETCH;
               end else begin
                  skid_pc_d    = req_pc_q;
                  skid_instr_d = imem_rdata_i;
                  state_d      = S_HOLD;
               end
            end else if (redirect) begin
               discard_d = 1'b1;
            end
         end
         S_HOLD: begin
            // Skid occupancy is implied by the state, so leaving it clears it.
            if (redirect) begin
               pc_d    = target;
               state_d = S_FETCH;
            end else if (!stall_i) begin
               load_skid = 1'b1;
               state_d   = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_comb begin
      valid_d  = valid_q;
      pc_out_d = pc_out_q;
      pcsrc_d  = pcsrc_q;
      instr_d  = instr_q;

      if (load_resp) begin
         valid_d  = 1'b1;
         pc_out_d = req_pc_q;
         pcsrc_d  = req_pc_q + 32'd4;
         instr_d  = imem_rdata_i;
      end else if (load_skid) begin
         valid_d  = 1'b1;
         pc_out_d = skid_pc_q;
         pcsrc_d  = skid_pc_q + 32'd4;
         instr_d  = skid_instr_q;
      end else if (redirect || !stall_i) begin
         // Flush on redirect even under stall; otherwise insert a bubble.
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         req_pc_q     <= 32'h0;
         skid_pc_q    <= 32'h0;
         skid_instr_q <= NOP_INSTR;
         discard_q    <= 1'b0;
         valid_q      <= 1'b0;
         pc_out_q     <= 32'h0;
         pcsrc_q      <= 32'h0;
         instr_q      <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         discard_q    <= discard_d;
         valid_q      <= valid_d;
         pc_out_q     <= pc_out_d;
         pcsrc_q      <= pcsrc_d;
         instr_q      <= instr_d;
      end
   end

   assign imem_req_o    = (state_q == S_FETCH) && !reset_i;
   assign imem_addr_o   = pc_q & WORD_MASK;
   assign valid_o       = valid_q;
   assign pc_o          = pc_out_q;
   assign pcsrc_o       = pcsrc_q;
   assign instruction_o = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage.
// The bench plays instruction memory. Each word's content is a fixed
// function of its address. Grant and response latency are random.
// The reference model is the architectural instruction stream. From reset
// or from the latest redirect target, decode must receive consecutive words
// at pc, pc+4, ... in order, and each word's instruction must be mem(pc).
// The driver rebuilds the expected queue on every reset or redirect.
// A negedge monitor pops an entry each time decode consumes an entry
// (valid, no stall, no redirect) and compares it.

module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int          CYCLES   = 4000;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [31:0] pc_new_i = 32'h0;
   logic        pc_select_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'h0;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] pcsrc_o;
   logic [31:0] instruction_o;

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .pc_new_i      (pc_new_i),
      .pc_select_i   (pc_select_i),
      .stall_i       (stall_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .valid_o       (valid_o),
      .pc_o          (pc_o),
      .pcsrc_o       (pcsrc_o),
      .instruction_o (instruction_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          delivered = 0;

   // memory-side bookkeeping: set by the monitor on grant, consumed by driver
   bit          outstanding = 1'b0;
   logic [31:0] out_addr = 32'h0;
   int          wait_cnt = 0;

   bit          prev_reset = 1'b1;
   bit          prev_redirect = 1'b0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_pc = 32'h0;
   logic [31:0] prev_pcsrc = 32'h0;
   logic [31:0] prev_instr = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected stream after a (re)start: sequential words from the aligned
   // start address, wrapping modulo 2^32.
   task automatic refill(input logic [31:0] start);
      logic [31:0] p;
      entry_t      e;
      exp_q.delete();
      p = start & 32'hFFFF_FFFC;
      for (int i = 0; i < 256; i++) begin
         e.pc    = p;
         e.instr = mem_word(p);
         exp_q.push_back(e);
         p = p + 32'd4;
      end
   endtask

   // driver: all inputs change 1 time unit after the rising edge
   initial begin
      refill(RESET_PC);
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b0;
      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         @(posedge clk_i);
         #1;
         if (cyc == 1500 || cyc == 1501 || cyc == 2800) begin
            reset_i       = 1'b1;
            pc_select_i   = 1'b0;
            stall_i       = 1'b0;
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            outstanding   = 1'b0;
            refill(RESET_PC);
            continue;
         end
         reset_i = 1'b0;
         stall_i = ($urandom_range(0, 99) < 30);
         pc_select_i = ($urandom_range(0, 99) < 6);
         if (pc_select_i) begin
            case ($urandom_range(0, 3))
               0: pc_new_i = $urandom_range(0, 4095);
               1: pc_new_i = 32'hFFFF_FFF0 | $urandom_range(0, 15);
               2: pc_new_i = $urandom;
               default: pc_new_i = 32'h0000_0100 + $urandom_range(0, 3);
            endcase
            refill(pc_new_i);
         end
         imem_gnt_i = ($urandom_range(0, 99) < 70);
         if (outstanding) begin
            if (wait_cnt == 0) begin
               imem_rvalid_i = 1'b1;
               imem_rdata_i  = mem_word(out_addr);
               outstanding   = 1'b0;
            end else begin
               imem_rvalid_i = 1'b0;
               imem_rdata_i  = $urandom;
               wait_cnt--;
            end
         end else begin
            // stray response with junk data while nothing is in flight
            imem_rvalid_i = ($urandom_range(0, 99) < 8);
            imem_rdata_i  = 32'hBAD0_0000 ^ $urandom_range(0, 65535);
         end
      end
      @(negedge clk_i);
      check("delivered_count_ok", 32'(delivered >= 100), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // monitor / scoreboard
   always @(negedge clk_i) begin
      entry_t e;
      if (reset_i) begin
         check("req_low_in_reset", 32'(imem_req_o), 32'd0);
      end else begin
         if (prev_reset) begin
            check("rst_valid", 32'(valid_o), 32'd0);
            check("rst_pc", pc_o, 32'h0);
            check("rst_pcsrc", pcsrc_o, 32'h0);
            check("rst_instr", instruction_o, NOP);
            check("rst_req", 32'(imem_req_o), 32'd1);
            check("rst_addr", imem_addr_o, RESET_PC);
         end
         if (imem_req_o)
            check("addr_aligned", imem_addr_o & 32'h3, 32'h0);
         if (!valid_o)
            check("nop_when_invalid", instruction_o, NOP);
         if (prev_redirect)
            check("flush_after_redirect", 32'(valid_o), 32'd0);
         if (prev_hold) begin
            check("stall_hold_valid", 32'(valid_o), 32'd1);
            check("stall_hold_pc", pc_o, prev_pc);
            check("stall_hold_pcsrc", pcsrc_o, prev_pcsrc);
            check("stall_hold_instr", instruction_o, prev_instr);
         end
         if (valid_o && !stall_i && !pc_select_i) begin
            delivered++;
            if (exp_q.size() == 0) begin
               check("unexpected_delivery", pc_o, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("deliver_pc", pc_o, e.pc);
               check("deliver_pcsrc", pcsrc_o, e.pc + 32'd4);
               check("deliver_instr", instruction_o, e.instr);
            end
         end
         if (imem_req_o && imem_gnt_i) begin
            outstanding = 1'b1;
            out_addr    = imem_addr_o;
            wait_cnt    = $urandom_range(0, 3);
         end
      end
      prev_reset    = reset_i;
      prev_redirect = pc_select_i && !reset_i;
      prev_hold     = valid_o && stall_i && !pc_select_i && !reset_i;
      prev_pc       = pc_o;
      prev_pcsrc    = pcsrc_o;
      prev_instr    = instruction_o;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage pipeline: owns the PC, issues instruction-memory requests, and presents {pc, pc+4, instruction, valid} to decode.
- Consumes the execute-stage redirect (new PC plus select) and flushes the fetch path on a taken branch or jump.
- Single outstanding imem request; one-entry skid buffer absorbs a response that arrives while decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instruction_o whenever valid_o=0 (addi x0,x0,0).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- pc_new_i  in  32  redirect target from execute
- pc_select_i  in  1  redirect strobe from execute; high = load pc_new_i this cycle
- stall_i  in  1  decode/hazard stall; high = hold IF/ID outputs
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address, word aligned
- imem_gnt_i  in  1  memory accepts request this cycle
- imem_rvalid_i  in  1  response valid (≥1 cycle after grant)
- imem_rdata_i  in  32  response instruction
- valid_o  out  1  IF/ID entry valid
- pc_o  out  32  PC of instruction_o
- pcsrc_o  out  32  pc_o + 4
- instruction_o  out  32  fetched instruction

Behaviour:
- All registers update on posedge clk_i; reset_i is sampled synchronously.
- Reset state:
  - pc_q=RESET_PC, state=FETCH, valid_o=0, pc_o=0, pcsrc_o=0, instruction_o=NOP_INSTR.
  - Skid buffer empty, discard=0.
  - imem_req_o forced 0 while reset_i=1.
- imem_req_o = (state==FETCH) & !reset_i.
- imem_addr_o = {pc_q[31:2],2'b00}.
- Redirect target is written to pc_q as {pc_new_i[31:2],2'b00}.
- pc_q+4 wraps modulo 2^32; 0xFFFF_FFFC advances to 0x0.
- Priority: reset > redirect > response/stall handling.
- FETCH state (request asserted):
  - gnt=1: req_pc<=pc_q, go WAIT. If redirect is also high, pc_q<=pc_new_i and discard<=1. Otherwise pc_q<=pc_q+4.
  - gnt=0 with redirect: pc_q<=pc_new_i and stay FETCH. The address may change while ungranted; the memory treats it as a new request.
- WAIT state (no request; one response outstanding):
  - rvalid & (discard|redirect): drop the data, discard<=0, go FETCH.
  - rvalid, output free: load outputs {1, req_pc, req_pc+4, rdata}, go FETCH. "Output free" = stall_i=0 or valid_o=0.
  - rvalid, output occupied (stall_i=1 & valid_o=1): capture into skid {req_pc, rdata}, go HOLD.
  - No rvalid, redirect: discard<=1, stay WAIT.
- HOLD state (skid full, no request):
  - redirect: clear skid, go FETCH.
  - stall_i=0: move skid to outputs (valid_o=1), go FETCH.
  - stall_i=1: hold.
- Output register, when no load occurs:
  - redirect: valid_o<=0 and instruction_o<=NOP_INSTR. This flushes even under stall.
  - stall_i=1: all outputs hold.
  - stall_i=0: valid_o<=0 and instruction_o<=NOP_INSTR (bubble). pc_o and pcsrc_o hold.
- imem_rvalid_i outside WAIT is ignored.
- Throughput: at most one instruction per 2 cycles. Minimum latency is 2 cycles from req to valid_o, with gnt on the first cycle and rvalid the next.
- pc_select_i held high for several cycles re-applies the redirect each cycle. This is harmless: same target, repeated flush.

Test Plan:
1. Reset release, RESET_PC=0: imem_req_o=1 with addr 0x0; gnt; next cycle rvalid with rdata 0x00500093 -> next cycle valid_o=1, pc_o=0x0, pcsrc_o=0x4, instruction_o=0x00500093. Next req addr is 0x4.
2. Redirect in WAIT: granted addr 0x8, then pc_select_i=1 with pc_new_i=0x100. Later rvalid (rdata 0xDEADBEEF) -> dropped; valid_o=0, instruction_o=0x13; next req addr 0x100.
3. Redirect coincident with gnt, addr 0x10, pc_new_i=0x200 -> response for 0x10 discarded; next req addr 0x200; no valid_o for 0x10.
4. Stall skid: valid_o=1 (pc 0x0) and stall_i=1; rvalid for 0x4 -> state HOLD, imem_req_o=0, outputs unchanged. Drop stall_i -> next cycle pc_o=0x4 with its instruction; req resumes at 0x8.
5. Misaligned redirect, pc_new_i=0x103 -> imem_addr_o=0x100. Redirect while valid_o=1 and stall_i=1 -> valid_o=0 next cycle.
6. reset_i pulsed in WAIT with skid empty -> imem_req_o=0 during reset. Then a late rvalid is ignored, and after release req addr=RESET_PC with valid_o=0.
